alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester, round-robin front end for one shared,
// multi-cycle ALU.
//
// Optional feature macro: ALU_ARB_TIMEOUT_EN. When it is defined, a BUSY
// phase with no alu_done for TIMEOUT_CYCLES cycles is aborted. The aborted
// operation completes with error=1 and result 16'h0000. When the macro is
// undefined, BUSY waits for alu_done indefinitely.
//
// Ports
//   clk, reset_n               clock; synchronous active-low reset
//   reqN_valid/a/b/op          requester N operation (N = 0,1); valid held until ready
//   reqN_ready                 one-cycle accept pulse to requester N
//   rspN_valid                 one-cycle response pulse to requester N
//   rspN_result/error          result and error of the last response to N (held)
//   alu_start                  level start, high for the whole BUSY phase
//   alu_a, alu_b, alu_op       operands/opcode to the ALU, stable during BUSY
//   alu_done/result/error      ALU completion, sampled only in BUSY
//   busy                       high whenever the FSM is not in IDLE
//
// Opcode type alu_opcode_t lives in alu_arbiter_pkg. Codes 6 and 7 are reserved.

package alu_arbiter_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } alu_opcode_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  alu_opcode_t req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  alu_opcode_t req1_op,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic        rsp0_error,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic        rsp1_error,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output alu_opcode_t alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_error,
  output logic        busy
);

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
    $error("alu_arbiter: TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        rr_ptr;    // requester that wins when both are valid
  logic        gnt_id;    // requester that owns the current operation
  logic [15:0] res_hold;  // ALU result captured on alu_done
  logic        err_hold;
  logic        pick;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // A lone request wins outright. Under contention the round-robin
  // pointer decides.
  always_comb begin
    pick = rr_ptr;
    if (req0_valid && !req1_valid) begin
      pick = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      gnt_id      <= 1'b0;
      res_hold    <= '0;
      err_hold    <= 1'b0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_error  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_error  <= 1'b0;
      alu_start   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_ADD;
      busy        <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      // Accept and response strobes are single-cycle pulses.
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt_id     <= pick;
            req0_ready <= ~pick;
            req1_ready <= pick;
            alu_a      <= pick ? req1_a  : req0_a;
            alu_b      <= pick ? req1_b  : req0_b;
            alu_op     <= pick ? req1_op : req0_op;
            alu_start  <= 1'b1;
            busy       <= 1'b1;
            state      <= BUSY;
`ifdef ALU_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end

        BUSY: begin
          if (alu_done) begin
            res_hold  <= alu_result;
            err_hold  <= alu_error;
            alu_start <= 1'b0;
            state     <= RESP;
`ifdef ALU_ARB_TIMEOUT_EN
          end else if (tmo_cnt == CNT_LAST) begin
            // Abort a hung ALU. The response reports an error with a zero result.
            res_hold  <= '0;
            err_hold  <= 1'b1;
            alu_start <= 1'b0;
            state     <= RESP;
          end else begin
            tmo_cnt   <= tmo_cnt + 1'b1;
`endif
          end
        end

        RESP: begin
          if (gnt_id) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= res_hold;
            rsp1_error  <= err_hold;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= res_hold;
            rsp0_error  <= err_hold;
          end
          // Hand priority to the requester that was not just served.
          rr_ptr <= ~gnt_id;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          alu_start <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  alu_opcode_t req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_result, rsp1_result;
  logic        rsp0_error, rsp1_error;
  logic        alu_start;
  logic [7:0]  alu_a, alu_b;
  alu_opcode_t alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_error;
  logic        busy;

  // requester drives, indexed by requester id
  logic        rv [2];
  logic [7:0]  ra [2];
  logic [7:0]  rb [2];
  alu_opcode_t rop [2];

  assign req0_valid = rv[0];
  assign req1_valid = rv[1];
  assign req0_a = ra[0];
  assign req1_a = ra[1];
  assign req0_b = rb[0];
  assign req1_b = rb[1];
  assign req0_op = rop[0];
  assign req1_op = rop[1];

  logic [1:0]  rdy, rspv;
  logic [15:0] rres [2];
  logic        rerr [2];
  assign rdy  = {req1_ready, req0_ready};
  assign rspv = {rsp1_valid, rsp0_valid};
  assign rres[0] = rsp0_result;
  assign rres[1] = rsp1_result;
  assign rerr[0] = rsp0_error;
  assign rerr[1] = rsp1_error;

  int total = 0;
  int bad = 0;

  // reference-model state
  int          rr;                 // round-robin owner per the arbitration rule
  bit          acc_live [2];       // accepted, response still owed
  alu_opcode_t acc_op [2];
  logic [7:0]  acc_a [2];
  logic [7:0]  acc_b [2];
  int          served_q[$];
  int          ready_cnt [2];
  int          rsp_cnt [2];
  bit          rsp_prev [2];
  bit          expect_timeout;

  // ALU model state
  int          alu_lat;
  int          alu_cnt;
  int          last_start_cycles;
  bit          alu_hang;
  logic [7:0]  hold_a, hold_b;
  alu_opcode_t hold_op;

  always #5 clk = ~clk;

  alu_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_error(rsp1_error),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
    .busy(busy)
  );

  // Arithmetic meaning of each opcode: {error, result}.
  function automatic logic [16:0] ref_alu(alu_opcode_t op, logic [7:0] a, logic [7:0] b);
    case (op)
      OP_ADD:  return {1'b0, 16'(a) + 16'(b)};
      OP_SUB:  return {1'b0, 16'(a) - 16'(b)};
      OP_MUL:  return {1'b0, 16'(a) * 16'(b)};
      OP_AND:  return {1'b0, 8'h00, a & b};
      OP_OR:   return {1'b0, 8'h00, a | b};
      OP_XOR:  return {1'b0, 8'h00, a ^ b};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  task automatic model_clear();
    rv[0] = 1'b0; rv[1] = 1'b0;
    alu_done = 1'b0; alu_result = 16'h0; alu_error = 1'b0;
    alu_cnt = 0; alu_hang = 1'b0; alu_lat = 1;
    rr = 0; expect_timeout = 1'b0;
    for (int n = 0; n < 2; n++) begin
      acc_live[n] = 1'b0; ready_cnt[n] = 0; rsp_cnt[n] = 0; rsp_prev[n] = 1'b0;
    end
    served_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
  endtask

  // One clock: requesters, ALU model and response scoreboard, sampled 1 after the edge.
  task automatic step();
    logic [1:0] rv_before = {rv[1], rv[0]};
    logic busy_before = busy;
    logic start_before = alu_start;
    logic [16:0] exp_rsp;
    @(posedge clk); #1;
    for (int n = 0; n < 2; n++) begin
      if (rdy[n]) begin
        total++;
        if (busy_before || !rv_before[n] || start_before) begin
          bad++;
          $display("FAIL ready_protocol[%0d]: busy_before=%0b valid_before=%0b start_before=%0b required 0/1/0",
                   n, busy_before, rv_before[n], start_before);
        end
        if (rv_before == 2'b11) begin
          total++;
          if (n != rr) begin
            bad++;
            $display("FAIL rr_grant: granted %0d required %0d", n, rr);
          end
        end
        acc_live[n] = 1'b1; acc_op[n] = rop[n]; acc_a[n] = ra[n]; acc_b[n] = rb[n];
        ready_cnt[n]++;
        rv[n] = 1'b0;
      end
      if (rspv[n]) begin
        exp_rsp = expect_timeout ? {1'b1, 16'h0000} : ref_alu(acc_op[n], acc_a[n], acc_b[n]);
        total++;
        if (!acc_live[n] || rsp_prev[n] || {rerr[n], rres[n]} !== exp_rsp) begin
          bad++;
          $display("FAIL rsp[%0d]: live=%0b prev=%0b err/result=%h required %h",
                   n, acc_live[n], rsp_prev[n], {rerr[n], rres[n]}, exp_rsp);
        end
        acc_live[n] = 1'b0;
        rsp_cnt[n]++;
        served_q.push_back(n);
        rr = 1 - n;
      end
      rsp_prev[n] = rspv[n];
    end
    // ALU model: done is a single-cycle pulse after alu_lat cycles of start.
    alu_done = 1'b0; alu_result = 16'h0; alu_error = 1'b0;
    if (alu_start) begin
      alu_cnt++;
      if (alu_cnt == 1) begin
        hold_a = alu_a; hold_b = alu_b; hold_op = alu_op;
      end else begin
        total++;
        if ({alu_a, alu_b, alu_op} !== {hold_a, hold_b, hold_op}) begin
          bad++;
          $display("FAIL operand_hold: got %h required %h", {alu_a, alu_b, alu_op}, {hold_a, hold_b, hold_op});
        end
      end
      if (!alu_hang && alu_cnt == alu_lat) begin
        {alu_error, alu_result} = ref_alu(alu_op, alu_a, alu_b);
        alu_done = 1'b1;
      end
    end else begin
      if (alu_cnt != 0) last_start_cycles = alu_cnt;
      alu_cnt = 0;
    end
  endtask

  task automatic run_until_quiet(input int budget, input string name);
    int c = 0;
    while ((rv[0] || rv[1] || busy || acc_live[0] || acc_live[1]) && c < budget) begin
      step();
      c++;
    end
    total++;
    if (c >= budget) begin
      bad++;
      $display("FAIL %s_drain: still active after %0d cycles, required idle", name, c);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if ({busy, alu_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {busy, alu_start, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_error, rsp1_error});
    end
    total++;
    if ({rsp0_result, rsp1_result} !== 32'h0) begin
      bad++;
      $display("FAIL reset_results: got %h required 0", {rsp0_result, rsp1_result});
    end
    total++;
    if ({alu_a, alu_b, alu_op} !== 19'h0) begin
      bad++;
      $display("FAIL reset_alu_drive: got %h required 0", {alu_a, alu_b, alu_op});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    rop[0] = OP_ADD; ra[0] = 8'h12; rb[0] = 8'h34; rv[0] = 1'b1; alu_lat = 1;
    run_until_quiet(50, "add");
    total++;
    if (ready_cnt[0] != 1 || rsp_cnt[0] != 1) begin
      bad++;
      $display("FAIL add_pulses: ready=%0d rsp=%0d required 1/1", ready_cnt[0], rsp_cnt[0]);
    end
    total++;
    if (rsp0_result !== 16'h0046 || rsp0_error !== 1'b0) begin
      bad++;
      $display("FAIL add_result: got %h err %b required 0046 err 0", rsp0_result, rsp0_error);
    end
    repeat (3) step();
    total++;
    if (rsp0_result !== 16'h0046) begin
      bad++;
      $display("FAIL add_hold: got %h required 0046", rsp0_result);
    end
  endtask

  task automatic test_both();
    do_reset();
    rop[0] = OP_ADD; ra[0] = 8'h01; rb[0] = 8'h02; rv[0] = 1'b1;
    rop[1] = OP_SUB; ra[1] = 8'h09; rb[1] = 8'h03; rv[1] = 1'b1;
    alu_lat = 2;
    run_until_quiet(60, "both");
    total++;
    if (served_q.size() != 2 || served_q[0] != 0 || served_q[1] != 1) begin
      bad++;
      $display("FAIL both_order: served %0d responses first=%0d required 2 responses 0 then 1",
               served_q.size(), (served_q.size() > 0) ? served_q[0] : -1);
    end
    total++;
    if (rsp1_result !== 16'h0006) begin
      bad++;
      $display("FAIL both_sub: got %h required 0006", rsp1_result);
    end
  endtask

  task automatic test_mul();
    rop[0] = OP_MUL; ra[0] = 8'hFF; rb[0] = 8'hFF; rv[0] = 1'b1; alu_lat = 6;
    run_until_quiet(60, "mul");
    total++;
    if (rsp0_result !== 16'hFE01 || last_start_cycles != 6) begin
      bad++;
      $display("FAIL mul: result %h start_cycles %0d required FE01 and 6", rsp0_result, last_start_cycles);
    end
  endtask

  task automatic test_reserved();
    rop[1] = OP_RSV6; ra[1] = 8'($urandom); rb[1] = 8'($urandom); rv[1] = 1'b1; alu_lat = 2;
    rsp_cnt[1] = 0;
    run_until_quiet(60, "reserved");
    total++;
    if (rsp_cnt[1] != 1 || rsp1_error !== 1'b1) begin
      bad++;
      $display("FAIL reserved: rsp1 count %0d error %b required 1 and 1", rsp_cnt[1], rsp1_error);
    end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 3; i++) begin
      alu_done = 1'b1; alu_error = 1'b1; alu_result = 16'($urandom);
      @(posedge clk); #1;
      total++;
      if ({busy, alu_start, rsp0_valid, rsp1_valid} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_noise: got %b required 0000", {busy, alu_start, rsp0_valid, rsp1_valid});
      end
    end
    alu_done = 1'b0; alu_error = 1'b0; alu_result = 16'h0;
  endtask

  task automatic test_timeout();
`ifdef ALU_ARB_TIMEOUT_EN
    alu_hang = 1'b1; expect_timeout = 1'b1;
    rop[0] = OP_ADD; ra[0] = 8'h05; rb[0] = 8'h06; rv[0] = 1'b1;
    run_until_quiet(100, "timeout");
    total++;
    if (rsp0_error !== 1'b1 || rsp0_result !== 16'h0000 || last_start_cycles != 8) begin
      bad++;
      $display("FAIL timeout: err %b result %h busy_cycles %0d required 1 0000 8",
               rsp0_error, rsp0_result, last_start_cycles);
    end
    alu_hang = 1'b0; expect_timeout = 1'b0;
`else
    alu_hang = 1'b1;
    rop[0] = OP_XOR; ra[0] = 8'hA5; rb[0] = 8'h0F; rv[0] = 1'b1;
    repeat (40) step();
    total++;
    if (busy !== 1'b1 || alu_start !== 1'b1) begin
      bad++;
      $display("FAIL no_timeout_wait: busy %b start %b required 1 1", busy, alu_start);
    end
    alu_lat = alu_cnt + 1; alu_hang = 1'b0;
    run_until_quiet(20, "no_timeout");
    total++;
    if (rsp0_result !== 16'h00AA || rsp0_error !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout_result: got %h err %b required 00AA err 0", rsp0_result, rsp0_error);
    end
`endif
  endtask

  task automatic test_reset_busy();
    do_reset();
    rop[0] = OP_XOR; ra[0] = 8'h3C; rb[0] = 8'hFF; rv[0] = 1'b1; alu_lat = 1;
    run_until_quiet(50, "rb_first");
    alu_hang = 1'b1;
    rop[1] = OP_OR; ra[1] = 8'h11; rb[1] = 8'h22; rv[1] = 1'b1;
    repeat (4) step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rb_setup: busy %b required 1", busy);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy, alu_start, rsp0_valid, rsp1_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rb_abort: got %b required 0000", {busy, alu_start, rsp0_valid, rsp1_valid});
    end
    @(posedge clk); #1;
    total++;
    if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
      bad++;
      $display("FAIL rb_no_rsp: got %b required 00", {rsp0_valid, rsp1_valid});
    end
    model_clear();
    reset_n = 1'b1;
    rop[0] = OP_AND; ra[0] = 8'hF0; rb[0] = 8'h3C; rv[0] = 1'b1;
    rop[1] = OP_ADD; ra[1] = 8'h80; rb[1] = 8'h80; rv[1] = 1'b1;
    run_until_quiet(60, "rb_after");
    total++;
    if (served_q.size() != 2 || served_q[0] != 0) begin
      bad++;
      $display("FAIL rb_pointer: served %0d first=%0d required 2 with 0 first",
               served_q.size(), (served_q.size() > 0) ? served_q[0] : -1);
    end
  endtask

  task automatic test_random();
    int acc_total, rsp_total;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] && !acc_live[n] && $urandom_range(0, 1) == 1) begin
          rop[n] = alu_opcode_t'(3'($urandom_range(0, 7)));
          ra[n] = 8'($urandom);
          rb[n] = 8'($urandom);
          rv[n] = 1'b1;
        end
      end
      if (!alu_start) alu_lat = $urandom_range(1, 4);
      step();
    end
    run_until_quiet(100, "random");
    acc_total = ready_cnt[0] + ready_cnt[1];
    rsp_total = rsp_cnt[0] + rsp_cnt[1];
    total++;
    if (acc_total != rsp_total || acc_total < 20) begin
      bad++;
      $display("FAIL random_count: accepted %0d responded %0d required equal and at least 20",
               acc_total, rsp_total);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      ra[n] = 8'h0; rb[n] = 8'h0; rop[n] = OP_ADD;
    end
    last_start_cycles = 0;
    hold_a = 8'h0; hold_b = 8'h0; hold_op = OP_ADD;
    model_clear();
    test_reset();
    test_add();
    test_both();
    test_mul();
    test_reserved();
    test_idle_noise();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
